// File: rtl/change_dispenser_if.sv
// change_dispenser_if: change-request handshake between vending controller and payout back end
interface change_dispenser_if;
    logic       chg_valid;
    logic [1:0] chg_code;
    logic       chg_ready;

    modport master (output chg_valid, output chg_code, input chg_ready);
    modport slave  (input chg_valid, input chg_code, output chg_ready);
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: buffers change codes, kicks Rs5/Rs10 hoppers coin by coin, tracks inventory
// Optional: define CHG_AUDIT_EN to build the total_paid audit counter (otherwise tied to 0).
module change_dispenser #(
    parameter int FIFO_DEPTH     = 4,
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int INV_W          = 8,
    parameter int INIT_INV5      = 20,
    parameter int INIT_INV10     = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    change_dispenser_if.slave    chg,
    input  logic                 drop5,
    input  logic                 drop10,
    input  logic                 refill,
    output logic                 kick5,
    output logic                 kick10,
    output logic                 busy,
    output logic                 empty5,
    output logic                 empty10,
    output logic                 fault,
    output logic [4:0]           owed,
    output logic [15:0]          total_paid
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES > PULSE_CYCLES ? TIMEOUT_CYCLES : PULSE_CYCLES) + 1;
    localparam int INV_MAX = (1 << INV_W) - 1;
    localparam logic [INV_W-1:0] LD5  = INV_W'(INIT_INV5  > INV_MAX ? INV_MAX : INIT_INV5);
    localparam logic [INV_W-1:0] LD10 = INV_W'(INIT_INV10 > INV_MAX ? INV_MAX : INIT_INV10);

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_KICK, S_WAIT} state_t;

    state_t           r_state;
    logic [1:0]       r_mem [FIFO_DEPTH];
    logic [PW-1:0]    r_wp, r_rp;
    logic [4:0]       r_rem;
    logic             r_coin10;
    logic [CW-1:0]    r_cnt;
    logic [INV_W-1:0] r_inv5, r_inv10;
    logic [1:0]       r_s5, r_s10;
    logic             r_p5, r_p10;
    logic             r_refill_pend;

    logic             w_empty, w_full, w_push, w_pop, w_edge, w_pay;
    logic [1:0]       w_head;
    logic [4:0]       w_coin;

    assign w_empty = r_wp == r_rp;
    assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_push  = chg.chg_valid && chg.chg_code != 2'b00 && !w_full;
    assign w_pop   = r_state == S_IDLE && !w_empty;
    assign w_head  = r_mem[r_rp[AW-1:0]];
    assign w_coin  = r_coin10 ? 5'd10 : 5'd5;
    // Only a rising edge on the hopper that was actually kicked counts as a payout
    assign w_edge  = r_coin10 ? (r_s10[1] & ~r_p10) : (r_s5[1] & ~r_p5);
    assign w_pay   = r_state == S_WAIT && w_edge;

    assign chg.chg_ready = !w_full;
    assign busy    = r_state != S_IDLE || !w_empty;
    assign empty5  = r_inv5 == '0;
    assign empty10 = r_inv10 == '0;

    // Request storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= chg.chg_code;
    end

    // Sensor sync, FIFO pointers and the dispense FSM with registered kick/fault outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_wp          <= '0;
            r_rp          <= '0;
            r_rem         <= '0;
            r_coin10      <= 1'b0;
            r_cnt         <= '0;
            r_inv5        <= LD5;
            r_inv10       <= LD10;
            r_s5          <= '0;
            r_s10         <= '0;
            r_p5          <= 1'b0;
            r_p10         <= 1'b0;
            r_refill_pend <= 1'b0;
            kick5         <= 1'b0;
            kick10        <= 1'b0;
            fault         <= 1'b0;
            owed          <= '0;
        end else begin
            r_s5  <= {r_s5[0], drop5};
            r_s10 <= {r_s10[0], drop10};
            r_p5  <= r_s5[1];
            r_p10 <= r_s10[1];
            r_wp  <= r_wp + PW'(w_push);
            r_rp  <= r_rp + PW'(w_pop);
            if (refill) r_refill_pend <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (refill || r_refill_pend) begin
                        r_inv5        <= LD5;
                        r_inv10       <= LD10;
                        fault         <= 1'b0;
                        r_refill_pend <= 1'b0;
                    end
                    if (!w_empty) begin
                        r_rem   <= 5'(w_head) * 5'd5;
                        r_state <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (r_rem == '0) begin
                        r_state <= S_IDLE;
                    end else if (r_rem >= 5'd10 && r_inv10 != '0) begin
                        r_coin10 <= 1'b1;
                        kick10   <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_KICK;
                    end else if (r_rem >= 5'd5 && r_inv5 != '0) begin
                        r_coin10 <= 1'b0;
                        kick5    <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= S_KICK;
                    end else begin
                        fault   <= 1'b1;
                        owed    <= r_rem;
                        r_rem   <= '0;
                        r_state <= S_IDLE;
                    end
                end
                S_KICK: begin
                    if (r_cnt == CW'(PULSE_CYCLES - 1)) begin
                        kick5   <= 1'b0;
                        kick10  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (w_edge) begin
                        if (r_coin10) r_inv10 <= r_inv10 - INV_W'(1);
                        else          r_inv5  <= r_inv5 - INV_W'(1);
                        r_rem   <= r_rem - w_coin;
                        r_state <= S_SELECT;
                    end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        // No drop seen: treat the hopper as jammed/empty so SELECT substitutes
                        if (r_coin10) r_inv10 <= '0;
                        else          r_inv5  <= '0;
                        r_state <= S_SELECT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CHG_AUDIT_EN
    logic [15:0] r_paid;

    // Audit total of confirmed coins, wrapping at 2^16
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_paid <= '0;
        else if (w_pay) r_paid <= r_paid + 16'(w_coin);
    end

    assign total_paid = r_paid;
`else
    assign total_paid = '0;
`endif
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: randomized scoreboard bench for change_dispenser with a coin-level reference model
module tb_change_dispenser;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        drop5 = 1'b0, drop10 = 1'b0, refill = 1'b0;
    logic        kick5, kick10, busy, empty5, empty10, fault;
    logic [4:0]  owed;
    logic [15:0] total_paid;

    change_dispenser_if bus();

    change_dispenser dut (
        .clk(clk), .reset(reset), .chg(bus), .drop5(drop5), .drop10(drop10), .refill(refill),
        .kick5(kick5), .kick10(kick10), .busy(busy), .empty5(empty5), .empty10(empty10),
        .fault(fault), .owed(owed), .total_paid(total_paid)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int exp_q[$];
    int m_inv5 = 20, m_inv10 = 20, m_owed = 0, m_paid = 0;
    bit m_fault = 0, jam5 = 0, jam10 = 0;
    int w5 = 0, w10 = 0, pend = 0, hold = 0, pd = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference: greedy largest-coin payout against the hopper contents; a jammed hopper
    // still gets kicked once, then reads as empty and the next denomination takes over.
    task automatic model_req(input int val);
        int rem = val;
        while (rem > 0) begin
            if (rem >= 10 && m_inv10 > 0) begin
                exp_q.push_back(10);
                if (jam10) m_inv10 = 0;
                else begin m_inv10--; rem -= 10; m_paid = (m_paid + 10) % 65536; end
            end else if (m_inv5 > 0) begin
                exp_q.push_back(5);
                if (jam5) m_inv5 = 0;
                else begin m_inv5--; rem -= 5; m_paid = (m_paid + 5) % 65536; end
            end else begin
                m_fault = 1; m_owed = rem; rem = 0;
            end
        end
    endtask

    task automatic send(input logic [1:0] c, output bit acc);
        bus.chg_valid = 1'b1;
        bus.chg_code  = c;
        acc = bus.chg_ready && c != 2'b00;
        @(posedge clk); #1;
        bus.chg_valid = 1'b0;
        bus.chg_code  = 2'b00;
        if (acc) model_req(5 * int'(c));
    endtask

    task automatic send1(input logic [1:0] c);
        bit a;
        send(c, a);
    endtask

    task automatic pulse_refill();
        refill = 1'b1;
        @(posedge clk); #1;
        refill = 1'b0;
        m_inv5 = 20; m_inv10 = 20; m_fault = 0;
    endtask

    task automatic wait_kick(input string tag);
        int n = 0;
        while (!(kick5 || kick10) && n < 50) begin @(posedge clk); #1; n++; end
        chk({tag, "_kick_seen"}, int'(kick5 || kick10), 1);
    endtask

    task automatic check_idle(input string tag);
        int n = 0;
        while (busy && n < 6000) begin @(posedge clk); #1; n++; end
        chk({tag, "_busy"}, int'(busy), 0);
        repeat (2) begin @(posedge clk); #1; end
        chk({tag, "_fault"}, int'(fault), int'(m_fault));
        chk({tag, "_owed"}, int'(owed), m_owed);
        chk({tag, "_empty5"}, int'(empty5), int'(m_inv5 == 0));
        chk({tag, "_empty10"}, int'(empty10), int'(m_inv10 == 0));
`ifdef CHG_AUDIT_EN
        chk({tag, "_total_paid"}, int'(total_paid), m_paid);
`else
        chk({tag, "_total_paid"}, int'(total_paid), 0);
`endif
        chk({tag, "_coins_left"}, exp_q.size(), 0);
        chk({tag, "_ready"}, int'(bus.chg_ready), 1);
    endtask

    // Monitor: scores each finished kick pulse against the model and plays the hopper's drop sensor
    always @(negedge clk) begin
        if (!reset) begin
            w5 = 0; w10 = 0; pend = 0; hold = 0;
            drop5 = 1'b0; drop10 = 1'b0;
        end else begin
            if (kick5 || kick10) chk("kick_exclusive", int'(kick5 && kick10), 0);
            if (hold > 0) begin
                hold--;
                if (hold == 0) begin drop5 = 1'b0; drop10 = 1'b0; end
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    if (pd == 10) drop10 = 1'b1; else drop5 = 1'b1;
                    hold = 3;
                end
            end
            for (int d = 5; d <= 10; d += 5) begin
                logic k;
                int   w;
                k = (d == 10) ? kick10 : kick5;
                w = (d == 10) ? w10 : w5;
                if (k) w++;
                else if (w > 0) begin
                    chk(d == 10 ? "kick10_width" : "kick5_width", w, 4);
                    if (exp_q.size() == 0) chk("coin_unexpected", d, 0);
                    else chk("coin_denom", d, exp_q.pop_front());
                    if (!((d == 10) ? jam10 : jam5)) begin
                        pend = $urandom_range(1, 20);
                        pd = d;
                    end
                    w = 0;
                end
                if (d == 10) w10 = w; else w5 = w;
            end
        end
    end

    initial begin
        bit acc;
        int n_acc;
        bus.chg_valid = 1'b0;
        bus.chg_code  = 2'b00;
        #22 reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", int'(bus.chg_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_kicks", int'(kick5 || kick10), 0);
        chk("rst_flags", int'({empty5, empty10, fault}), 0);
        chk("rst_owed", int'(owed), 0);
        chk("rst_total", int'(total_paid), 0);

        send1(2'b01);
        check_idle("rs5");
        send1(2'b11);
        check_idle("rs15");

        jam10 = 1;
        send1(2'b10);
        check_idle("jam10");
        jam10 = 0;

        send1(2'b01);
        wait_kick("busy_refill");
        pulse_refill();
        repeat (3) begin @(posedge clk); #1; end
        chk("refill_held_empty10", int'(empty10), 1);
        check_idle("busy_refill");

        for (int i = 0; i < 25; i++) begin
            send1(2'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        check_idle("random");

        pulse_refill();
        jam5 = 1; jam10 = 1;
        send1(2'b11);
        check_idle("jam_both");
        send1(2'b01);
        check_idle("no_inv");
        pulse_refill();
        check_idle("refill");

        send1(2'b01);
        wait_kick("fifo");
        n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            send(2'b11, acc);
            n_acc += int'(acc);
        end
        chk("fifo_accepted", n_acc, 4);
        chk("fifo_ready_full", int'(bus.chg_ready), 0);
        check_idle("fifo");
        pulse_refill();
        jam5 = 0; jam10 = 0;
        check_idle("pre_reset");

        send1(2'b10);
        wait_kick("midreset");
        #2 reset = 1'b0;
        #1;
        chk("midreset_kicks", int'(kick5 || kick10), 0);
        chk("midreset_busy", int'(busy), 0);
        exp_q.delete();
        m_inv5 = 20; m_inv10 = 20; m_fault = 0; m_owed = 0; m_paid = 0;
        #13 reset = 1'b1;
        @(posedge clk); #1;
        check_idle("after_reset");
        send1(2'b11);
        check_idle("post_reset_rs15");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
